// File: rtl/mux2to1_32.sv
// Two-way word select with a registered, enable-gated copy of the result,
// a change-detect pulse and a saturating count of loads taken on the alternate path.
module mux2to1_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic             upd,
    output logic [CNT_W-1:0] sel_cnt
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_reg_q, sel_reg_d;
    logic             upd_q, upd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    assign out = sel ? in1 : in0;

    always_comb begin
        data_d    = data_q;
        sel_reg_d = sel_reg_q;
        cnt_d     = cnt_q;
        upd_d     = 1'b0;
        if (en) begin
            data_d    = out;
            sel_reg_d = sel;
            upd_d     = (out != data_q);
            if (sel) begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            sel_reg_q <= 1'b0;
            upd_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            data_q    <= data_d;
            sel_reg_q <= sel_reg_d;
            upd_q     <= upd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_q   = data_q;
    assign sel_q   = sel_reg_q;
    assign upd     = upd_q;
    assign sel_cnt = cnt_q;

endmodule

// File: tb/tb_mux2to1_32.sv
// Randomized self-checking bench for mux2to1_32 against a small behavioural model.
module tb_mux2to1_32;
    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sel = 1'b0;
    logic          en  = 1'b0;
    logic [W-1:0]  in0 = '0;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  out, out_q;
    logic          sel_q, upd;
    logic [CW-1:0] sel_cnt;

    int n_tot = 0;
    int n_bad = 0;

    // Reference state
    logic [W-1:0]  m_q   = '0;
    logic          m_sel = 1'b0;
    logic          m_upd = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    mux2to1_32 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sel(sel), .in0(in0), .in1(in1), .en(en),
        .out(out), .out_q(out_q), .sel_q(sel_q), .upd(upd), .sel_cnt(sel_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (s) return b;
        return a;
    endfunction

    task automatic model_reset();
        m_q = '0; m_sel = 1'b0; m_upd = 1'b0; m_cnt = '0;
    endtask

    // Advance one rising edge and update the model from the inputs seen there.
    task automatic edge_step();
        logic [W-1:0] v;
        @(posedge clk);
        v = pick(sel, in0, in1);
        if (!rst) begin
            model_reset();
        end else if (en) begin
            m_upd = (v != m_q);
            m_q   = v;
            m_sel = sel;
            if (sel && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end else begin
            m_upd = 1'b0;
        end
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".out_q"},   out_q,   m_q);
        check({tag, ".sel_q"},   sel_q,   m_sel);
        check({tag, ".upd"},     upd,     m_upd);
        check({tag, ".sel_cnt"}, sel_cnt, m_cnt);
    endtask

    // Apply inputs, check the combinational path, clock once, check registers.
    task automatic drive(input string tag, input logic s, input logic e,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        sel = s; en = e; in0 = a; in1 = b;
        #1;
        check({tag, ".out"}, out, pick(s, a, b));
        edge_step();
        check_regs(tag);
    endtask

    initial begin
        logic [W-1:0] r0, r1;

        // Held in reset while the clock runs with en=1
        en = 1'b1; sel = 1'b1; in1 = 32'h1111_2222;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_q", out_q, 0);
        check("rst.sel_q", sel_q, 0);
        check("rst.upd", upd, 0);
        check("rst.sel_cnt", sel_cnt, 0);
        check("rst.out", out, 32'h1111_2222);
        rst = 1'b1;

        // Combinational select, zero latency
        sel = 1'b0; en = 1'b0; in0 = 32'h0000_0004; in1 = 32'h0000_00C0;
        #1 check("comb.sel0", out, 32'h0000_0004);
        sel = 1'b1;
        #1 check("comb.sel1", out, 32'h0000_00C0);

        // First load then repeated identical load
        drive("load1", 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        check("load1.k_out_q", out_q, 32'hDEAD_BEEF);
        check("load1.k_upd", upd, 1);
        check("load1.k_cnt", sel_cnt, 1);
        drive("load2", 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        check("load2.k_upd", upd, 0);
        check("load2.k_cnt", sel_cnt, 2);

        // Freeze with en=0 while inputs toggle
        for (int i = 0; i < 5; i++)
            drive("freeze", i[0], 1'b0, $urandom, $urandom);
        check("freeze.k_out_q", out_q, 32'hDEAD_BEEF);

        // Asynchronous reset between edges
        drive("pre_rst", 1'b0, 1'b1, 32'h1234_5678, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_regs("arst");
        check("arst.out", out, 32'h1234_5678);
        sel = 1'b1; in1 = 32'hCAFE_0001;
        #1 check("arst.out_follow", out, 32'hCAFE_0001);
        @(negedge clk);
        rst = 1'b1;
        // First load after release compares against zero
        drive("post_rst_zero", 1'b0, 1'b1, 32'h0, 32'h5);
        check("post_rst_zero.k_upd", upd, 0);
        drive("post_rst_val", 1'b0, 1'b1, 32'h7, 32'h5);

        // Equal operands with sel toggling
        for (int i = 0; i < 6; i++)
            drive("equal", i[0], 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r0 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? r0 : W'($urandom);
            drive("rand", 1'($urandom), ($urandom_range(0, 3) != 0), r0, r1);
        end

        // Saturation: reset, preload 0xFFFE sel=1 loads, then push past the top
        @(negedge clk);
        rst = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst = 1'b1;
        sel = 1'b1; en = 1'b1; in0 = 32'h0; in1 = 32'h0BAD_F00D;
        for (int i = 0; i < 32'hFFFE; i++) edge_step();
        check("sat.preload", sel_cnt, 16'hFFFE);
        check_regs("sat.pre");
        for (int i = 0; i < 3; i++) drive("sat", 1'b1, 1'b1, 32'h0, $urandom);
        check("sat.top", sel_cnt, 16'hFFFF);
        drive("sat.sel0", 1'b0, 1'b1, $urandom, 32'h0);
        drive("sat.hold", 1'b1, 1'b0, $urandom, $urandom);
        check("sat.held", sel_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/mux2to1_32.md
MUX2TO1_32 -- requirements
Module: mux2to1_32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the data path width of in0, in1, out and out_q.
REQ-002 The block SHALL have parameter CNT_W, default 16, which sets the width of the select-event counter.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all registers update on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-005 Port sel SHALL be an input, 1 bit wide: 0 selects in0, 1 selects in1.
REQ-006 Port in0 SHALL be an input, WIDTH bits wide, and is the default-path operand (e.g. PC+4).
REQ-007 Port in1 SHALL be an input, WIDTH bits wide, and is the alternate-path operand (e.g. branch target).
REQ-008 Port en SHALL be an input, 1 bit wide, and is the load enable for the registered stage.
REQ-009 Port out SHALL be an output, WIDTH bits wide, and is the combinational mux result.
REQ-010 Port out_q SHALL be an output, WIDTH bits wide, and is the registered mux result.
REQ-011 Port sel_q SHALL be an output, 1 bit wide, and is the registered copy of sel.
REQ-012 Port upd SHALL be an output, 1 bit wide, and is a one-cycle pulse indicating that out_q was loaded with a value different from its previous value.
REQ-013 Port sel_cnt SHALL be an output, CNT_W bits wide, and is the saturating count of loads taken with sel=1.

Function
REQ-014 out SHALL equal in1 when sel=1 and in0 when sel=0, purely combinationally, with zero latency and no clock dependence.
REQ-015 out SHALL NOT be affected by rst or en.
REQ-016 On a rising clk edge with en=1, out_q SHALL load the current out value and sel_q SHALL load the current sel, giving 1-cycle latency from inputs to out_q.
REQ-017 On a rising clk edge with en=0, out_q, sel_q and sel_cnt SHALL hold their values (freeze).
REQ-018 upd SHALL be 1 for exactly the cycle after an en=1 edge where the newly loaded out value differs from the prior out_q; otherwise upd SHALL be 0, including on en=0 cycles.
REQ-019 sel_cnt SHALL increment by 1 on each en=1 edge with sel=1.
REQ-020 sel_cnt SHALL saturate at all-ones (0xFFFF at default CNT_W) and SHALL NOT wrap.
REQ-021 Only bit-for-bit selection SHALL be performed; there SHALL be no arithmetic, sign extension or width change on data.
REQ-022 When in0 equals in1, out SHALL be independent of sel, and a load SHALL still update sel_q and sel_cnt.

Reset
REQ-023 While rst=0, out_q, sel_q, upd and sel_cnt SHALL all be 0, asynchronously, regardless of clk and en.
REQ-024 When rst asserts mid-operation, it SHALL clear all registers immediately, and the combinational out SHALL keep following sel, in0 and in1.
REQ-025 On the first rising edge after rst deasserts, normal operation SHALL apply, with upd computed against out_q=0.

Verification
REQ-026 Scenario: sel=0, in0=0x00000004, in1=0x000000C0 -> out=0x00000004 immediately; sel=1 -> out=0x000000C0 in the same cycle.
REQ-027 Scenario: en=1, sel=1, in1=0xDEADBEEF, edge -> out_q=0xDEADBEEF, sel_q=1, upd=1, sel_cnt=1; next edge with identical inputs -> upd=0, sel_cnt=2.
REQ-028 Scenario: en=0 while in0 and in1 toggle for 5 edges -> out follows the inputs, while out_q, sel_q and sel_cnt stay unchanged and upd=0.
REQ-029 Scenario: assert rst between edges while out_q=0x12345678 -> out_q=0, sel_cnt=0 and upd=0 immediately, with out still valid.
REQ-030 Scenario: preload 0xFFFE sel=1 loads (en=1, sel=1) -> sel_cnt=0xFFFE; 3 more such loads -> sel_cnt=0xFFFF and held.
REQ-031 Scenario: in0=in1=0xA5A5A5A5, sel toggling with en=1 -> out constant, upd=0 after the first load, and sel_q tracks sel.
